// File: rtl/id_ex_reg_pkg.sv
// Shared ID/EX pipeline definitions.
//   ctrl_t   : control bundle that travels from decode to execute (10 bits)
//   CTRL_NOP : all-zero bundle, i.e. an instruction with no side effects
//   XLEN_DEF / RA_W_DEF : default datapath and register-address widths
package id_ex_reg_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] immsel;
    logic       branch;
    logic [1:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_reg_pipe_field_reg.sv
// Width-parameterised pipeline flop with synchronous reset, clear and hold.
// Priority: reset > clear > hold > load.
//   clk   : rising-edge clock
//   reset : synchronous active-high, forces q to 0
//   hold  : keep q unchanged
//   clear : load 0 (wins over hold)
//   d / q : data in / registered data out
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (!hold) q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble insert), valid bit
// and a saturating count of bubbles entering EX.
//   clk, reset    : clock, synchronous active-high reset
//   stall, flush  : hold everything / load a bubble (flush wins)
//   id_*          : decode-stage slot (control bundle, valid, datapath fields)
//   ex_*          : registered copy presented to EX
//   bubble_cnt    : bubbles that entered EX, saturating at all ones
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_regwrite,
  input  logic             id_branch,
  input  logic             id_alusrc,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic [1:0]       id_immsel,
  input  logic [1:0]       id_aluop,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_branch,
  output logic             ex_alusrc,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic [1:0]       ex_immsel,
  output logic [1:0]       ex_aluop,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int CW  = $bits(ctrl_t) + 1;
  localparam int DPW = 4*XLEN + 3*RA_W + 4;

  ctrl_t          id_ctrl, ex_ctrl;
  logic [CW-1:0]  ctl_d, ctl_q;
  logic [DPW-1:0] dp_d, dp_q;
  logic           bubble_in;

  always_comb begin
    id_ctrl          = CTRL_NOP;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.immsel   = id_immsel;
    id_ctrl.branch   = id_branch;
    id_ctrl.aluop    = id_aluop;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.memread  = id_memread;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.memtoreg = id_memtoreg;
  end

  assign ctl_d = {id_valid, id_ctrl};

  // Valid travels with the control bundle so a flush kills both together.
  pipe_field_reg #(.W(CW)) u_ctl (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .clear (flush),
    .d     (ctl_d),
    .q     (ctl_q)
  );

  assign {ex_valid, ex_ctrl} = ctl_q;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_immsel   = ex_ctrl.immsel;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;

  assign dp_d = {id_pc, id_rs1_data, id_rs2_data, id_imm,
                 id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5};

  // Datapath is never cleared; on flush it still loads (even under stall)
  // so the bubble carries the current slot's harmless operand values.
  pipe_field_reg #(.W(DPW)) u_dp (
    .clk   (clk),
    .reset (reset),
    .hold  (stall & ~flush),
    .clear (1'b0),
    .d     (dp_d),
    .q     (dp_q)
  );

  assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
          ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5} = dp_q;

  // A bubble enters EX on flush, or on an unheld load of an invalid slot.
  assign bubble_in = flush | (~stall & ~id_valid);

  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (bubble_in && !(&bubble_cnt))
      bubble_cnt <= bubble_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
  } dp_t;

  typedef struct {
    int          cyc;
    logic [10:0] ctl;
    dp_t         dp;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush;
  logic id_valid, id_regwrite, id_branch, id_alusrc, id_memread, id_memwrite, id_memtoreg;
  logic [1:0] id_immsel, id_aluop;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic id_funct7b5;
  logic ex_valid, ex_regwrite, ex_branch, ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg;
  logic [1:0] ex_immsel, ex_aluop;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_funct7b5;
  logic [3:0] bubble_cnt;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  id_ex_reg #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_branch(id_branch),
    .id_alusrc(id_alusrc), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_immsel(id_immsel), .id_aluop(id_aluop),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_branch(ex_branch),
    .ex_alusrc(ex_alusrc), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_immsel(ex_immsel), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .bubble_cnt(bubble_cnt)
  );

  // ctl layout: {valid, regwrite, immsel[1:0], branch, aluop[1:0], alusrc, memread, memwrite, memtoreg}
  function automatic dp_t mk_dp(input logic [31:0] pc, input logic [4:0] rd);
    dp_t d;
    d.pc       = pc;
    d.rs1_data = 32'hA000_0000 | pc;
    d.rs2_data = 32'hB000_0000 | pc;
    d.imm      = pc >> 2;
    d.rs1      = 5'(rd + 5'd1);
    d.rs2      = 5'(rd + 5'd2);
    d.rd       = rd;
    d.funct3   = rd[2:0];
    d.funct7b5 = rd[0];
    return d;
  endfunction

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [10:0] ctl, input dp_t d);
    reset = r; stall = s; flush = f;
    {id_valid, id_regwrite, id_immsel, id_branch, id_aluop,
     id_alusrc, id_memread, id_memwrite, id_memtoreg} = ctl;
    {id_pc, id_rs1_data, id_rs2_data, id_imm,
     id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5} = d;
  endtask

  task automatic expect_next(input logic [10:0] ctl, input dp_t d, input logic [3:0] cnt);
    exp_t e;
    e.cyc = cyc + 1;
    e.ctl = ctl;
    e.dp  = d;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, c, act, req);
    end
  endtask

  // Monitor: compares the registered outputs against the entry due this cycle.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [10:0] act_ctl;
      e = q.pop_front();
      act_ctl = {ex_valid, ex_regwrite, ex_immsel, ex_branch, ex_aluop,
                 ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg};
      chk("due_cycle", e.cyc, cyc, e.cyc);
      chk("ctrl", e.cyc, {21'd0, act_ctl}, {21'd0, e.ctl});
      chk("pc", e.cyc, ex_pc, e.dp.pc);
      chk("rs1_data", e.cyc, ex_rs1_data, e.dp.rs1_data);
      chk("rs2_data", e.cyc, ex_rs2_data, e.dp.rs2_data);
      chk("imm", e.cyc, ex_imm, e.dp.imm);
      chk("regaddr", e.cyc, {17'd0, ex_rs1, ex_rs2, ex_rd},
          {17'd0, e.dp.rs1, e.dp.rs2, e.dp.rd});
      chk("funct", e.cyc, {28'd0, ex_funct3, ex_funct7b5},
          {28'd0, e.dp.funct3, e.dp.funct7b5});
      chk("bubble_cnt", e.cyc, {28'd0, bubble_cnt}, {28'd0, e.cnt});
    end
  end

  initial begin
    dp_t ones, zero, da, ds, db, dc, dd, de;
    ones = '1;
    zero = '0;

    // Reset with all inputs high, including stall and then flush.
    drive(1, 1, 0, 11'h7FF, ones); expect_next(11'h000, zero, 4'd0); tick();
    drive(1, 1, 1, 11'h7FF, ones); expect_next(11'h000, zero, 4'd0); tick();
    drive(0, 0, 0, 11'h7FF, ones); expect_next(11'h7FF, ones, 4'd0); tick();

    // Normal load: valid, regwrite, aluop=10.
    da = mk_dp(32'h100, 5'd5);
    drive(0, 0, 0, 11'h620, da); expect_next(11'h620, da, 4'd0); tick();

    // Stall 3 cycles with changing pc and an invalid slot: hold, no count.
    for (int i = 1; i <= 3; i++) begin
      ds = da;
      ds.pc = 32'h100 + 32'(4 * i);
      drive(0, 1, 0, 11'h220, ds); expect_next(11'h620, da, 4'd0); tick();
    end
    db = da;
    db.pc = 32'h10C;
    drive(0, 0, 0, 11'h620, db); expect_next(11'h620, db, 4'd0); tick();

    // Flush with stall: bubble wins, datapath still loads, count +1.
    dc = mk_dp(32'h200, 5'd9);
    drive(0, 1, 1, 11'h402, dc); expect_next(11'h000, dc, 4'd1); tick();

    // Upstream bubbles for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      dd = mk_dp(32'h300 + 32'(4 * i), 5'(i));
      drive(0, 0, 0, 11'h000, dd); expect_next(11'h000, dd, 4'(2 + i)); tick();
    end

    // Other control patterns.
    dd = mk_dp(32'h400, 5'd10);
    drive(0, 0, 0, 11'h48D, dd); expect_next(11'h48D, dd, 4'd5); tick();
    dd = mk_dp(32'h404, 5'd17);
    drive(0, 0, 0, 11'h550, dd); expect_next(11'h550, dd, 4'd5); tick();

    // Flush held 20 cycles: count saturates at 15.
    for (int i = 0; i < 20; i++) begin
      de = mk_dp(32'h500 + 32'(4 * i), 5'd3);
      drive(0, 0, 1, 11'h620, de);
      expect_next(11'h000, de, (6 + i > 15) ? 4'd15 : 4'(6 + i));
      tick();
    end

    // Reset pulse clears the counter and outputs, then a normal load.
    drive(1, 0, 0, 11'h620, de); expect_next(11'h000, zero, 4'd0); tick();
    drive(0, 0, 0, 11'h620, da); expect_next(11'h620, da, 4'd0); tick();

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
